// File: rtl/deserializador_rx_bc.sv
// Serial-to-parallel receive stage: finds byte alignment on the 0xBC comma,
// locks after LOCK_COUNT aligned commas, then emits one byte per 8-bit slot.
module deserializador_rx_bc #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         CNT_W      = 3
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       comma_det,
    output logic [1:0] o_state_dbg
);

    // Handshake: valid_out qualifies data_out for the whole 8-clock slot; there
    // is no ready, the downstream demux must accept every slot.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    state_t           r_state, w_state_n;
    // Only the 7 newest bits are kept; the 8th comes straight from data_in.
    logic [6:0]       r_sr;
    logic [2:0]       r_bit_cnt, w_bit_cnt_n;
    logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_n, w_lock_inc;
    logic [7:0]       r_data_out, w_data_out_n;
    logic             r_valid, w_valid_n;
    logic             r_active, w_active_n;
    logic             r_comma_det, w_comma_det_n;
    logic [7:0]       w_nxt;
    logic             w_is_comma;
    logic             w_boundary;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_sr        <= 7'd0;
            r_bit_cnt   <= 3'd0;
            r_lock_cnt  <= '0;
            r_data_out  <= 8'h00;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_comma_det <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sr        <= w_nxt[6:0];
            r_bit_cnt   <= w_bit_cnt_n;
            r_lock_cnt  <= w_lock_cnt_n;
            r_data_out  <= w_data_out_n;
            r_valid     <= w_valid_n;
            r_active    <= w_active_n;
            r_comma_det <= w_comma_det_n;
        end
    end

    always_comb begin
        w_nxt         = {r_sr, data_in};
        w_is_comma    = (w_nxt == COMMA);
        w_boundary    = (r_bit_cnt == 3'd7);
        w_lock_inc    = r_lock_cnt + ONE_VAL;
        w_state_n     = r_state;
        w_bit_cnt_n   = r_bit_cnt;
        w_lock_cnt_n  = r_lock_cnt;
        w_data_out_n  = r_data_out;
        w_valid_n     = r_valid;
        w_active_n    = r_active;
        w_comma_det_n = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_is_comma) begin
                    w_bit_cnt_n   = 3'd0;
                    w_lock_cnt_n  = ONE_VAL;
                    w_comma_det_n = 1'b1;
                    if (LOCK_VAL == ONE_VAL) begin
                        w_state_n  = ACTIVE;
                        w_active_n = 1'b1;
                    end else begin
                        w_state_n = LOCKING;
                    end
                end
            end
            LOCKING: begin
                w_bit_cnt_n = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_lock_cnt_n  = w_lock_inc;
                        w_comma_det_n = 1'b1;
                        if (w_lock_inc == LOCK_VAL) begin
                            w_state_n  = ACTIVE;
                            w_active_n = 1'b1;
                        end
                    end else begin
                        w_lock_cnt_n = '0;
                        w_bit_cnt_n  = 3'd0;
                        w_state_n    = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Alignment is trusted once locked; only reset leaves ACTIVE.
                w_bit_cnt_n = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    w_data_out_n  = w_nxt;
                    w_valid_n     = !w_is_comma;
                    w_comma_det_n = w_is_comma;
                end
            end
            default: begin
                w_state_n = SEARCH;
            end
        endcase
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid;
    assign active      = r_active;
    assign comma_det   = r_comma_det;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_deserializador_rx_bc.sv
// Directed bench for deserializador_rx_bc: lock, payload, misaligned lock,
// failed lock, and async reset mid-payload.
module tb_deserializador_rx_bc;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       comma_det;
    logic [1:0] o_state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_LOCKING = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;

    deserializador_rx_bc dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .comma_det   (comma_det),
        .o_state_dbg (o_state_dbg)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, return 1 time unit after the rising edge.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Sends a byte MSB first; optionally checks the slot-hold behaviour on the
    // first seven bits (no comma pulse, data_out/valid_out unchanged).
    task automatic send_byte(input logic [7:0] v, input logic chk_mid,
                             input logic [7:0] hold_d, input logic hold_v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (chk_mid && i > 0) begin
                chk("mid_comma_det", {7'd0, comma_det}, 8'h00);
                chk("mid_data_hold", data_out, hold_d);
                chk("mid_valid_hold", {7'd0, valid_out}, {7'd0, hold_v});
            end
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] d, input logic v,
                            input logic a, input logic c, input logic [1:0] st);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_valid"}, {7'd0, valid_out}, {7'd0, v});
        chk({tag, "_active"}, {7'd0, active}, {7'd0, a});
        chk({tag, "_comma"}, {7'd0, comma_det}, {7'd0, c});
        chk({tag, "_state"}, {6'd0, o_state_dbg}, {6'd0, st});
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 1'b0;

        // 1: reset held low with random serial data
        for (int i = 0; i < 20; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            chk_outs("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0, ST_SEARCH);
        end
        @(negedge clk_32f);
        reset = 1'b1;

        // 2: four aligned commas -> lock
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        chk_outs("lock1", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("lock2", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("lock3", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("lock4", 8'h00, 1'b0, 1'b1, 1'b1, ST_ACTIVE);

        // 3: payload 7D, F4, then an idle comma
        send_byte(8'h7D, 1'b1, 8'h00, 1'b0);
        chk_outs("pay_7d", 8'h7D, 1'b1, 1'b1, 1'b0, ST_ACTIVE);
        send_byte(8'hF4, 1'b1, 8'h7D, 1'b1);
        chk_outs("pay_f4", 8'hF4, 1'b1, 1'b1, 1'b0, ST_ACTIVE);
        send_byte(8'hBC, 1'b1, 8'hF4, 1'b1);
        chk_outs("idle_bc", 8'hBC, 1'b0, 1'b1, 1'b1, ST_ACTIVE);
        send_bit(1'b0);
        chk_outs("idle_after", 8'hBC, 1'b0, 1'b1, 1'b0, ST_ACTIVE);

        // 4: reset, then 3 junk bits shift alignment by 3
        #2;
        reset = 1'b0;
        #1;
        chk_outs("rst4", 8'h00, 1'b0, 1'b0, 1'b0, ST_SEARCH);
        @(negedge clk_32f);
        reset = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk_outs("junk", 8'h00, 1'b0, 1'b0, 1'b0, ST_SEARCH);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        chk_outs("off3_l1", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("off3_l4", 8'h00, 1'b0, 1'b1, 1'b1, ST_ACTIVE);
        send_byte(8'h3C, 1'b1, 8'h00, 1'b0);
        chk_outs("off3_3c", 8'h3C, 1'b1, 1'b1, 1'b0, ST_ACTIVE);

        // 5: lock broken by a non-comma at a boundary
        #2;
        reset = 1'b0;
        @(negedge clk_32f);
        reset = 1'b1;
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("brk_bc2", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'h5A, 1'b1, 8'h00, 1'b0);
        chk_outs("brk_5a", 8'h00, 1'b0, 1'b0, 1'b0, ST_SEARCH);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        chk_outs("rel_l1", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("rel_l3", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("rel_l4", 8'h00, 1'b0, 1'b1, 1'b1, ST_ACTIVE);

        // 6: async reset mid-payload while active, then re-lock
        send_byte(8'h66, 1'b1, 8'h00, 1'b0);
        chk_outs("pre_rst", 8'h66, 1'b1, 1'b1, 1'b0, ST_ACTIVE);
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, ST_SEARCH);
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        chk_outs("relock3", 8'h00, 1'b0, 1'b0, 1'b1, ST_LOCKING);
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        chk_outs("relock4", 8'h00, 1'b0, 1'b1, 1'b1, ST_ACTIVE);
        send_byte(8'hA5, 1'b1, 8'h00, 1'b0);
        chk_outs("pay_a5", 8'hA5, 1'b1, 1'b1, 1'b0, ST_ACTIVE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
